// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU datapath (load/store)
// and the display scanner that reads puzzle-cell words for the 7-seg io.
// Contention is resolved combinationally every cycle. The CPU is stalled when
// it loses the port. The scanner is guaranteed forward progress, either by a
// starvation guard (POLICY=0) or by strict alternation (POLICY=1). A
// saturating counter of stall cycles is kept for debug.
//
// Ports:
//   clk        divided system clock, all state on its rising edge
//   rst_n      synchronous active-low reset
//   cpu_req    CPU access this cycle        cpu_we     CPU access is a store
//   cpu_addr   CPU address                  cpu_wdata  CPU store data
//   cpu_rdata  load data (= mem_rdata)      cpu_stall  CPU lost arbitration
//   scn_req    scanner read request         scn_addr   scanner address
//   scn_gnt    scanner owns the port        scn_rdata  registered read data
//   scn_rvalid one-cycle pulse, scn_rdata valid
//   mem_addr / mem_we / mem_wdata  to memory, mem_rdata from memory (comb read)
//   stall_cnt  saturating count of cpu_stall cycles
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DW       = 26,
    parameter int AW       = 8,
    parameter int MAX_WAIT = 4,
    parameter int POLICY   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          scn_req,
    input  logic [AW-1:0] scn_addr,
    output logic          scn_gnt,
    output logic [DW-1:0] scn_rdata,
    output logic          scn_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cnt
);

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_SCN = 1'b1
    } gnt_e;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]    r_wait_cnt;
    gnt_e          r_last_gnt;
    logic [DW-1:0] r_scn_rdata;
    logic          r_scn_rvalid;
    logic [15:0]   r_stall_cnt;

    logic w_cpu_win;
    logic w_scn_win;

    // Grant decision. Reset masks both grants so nothing reaches memory
    // (in particular no store) while rst_n is low.
    always_comb begin
        w_cpu_win = 1'b0;
        w_scn_win = 1'b0;
        if (cpu_req && scn_req) begin
            if (POLICY == 0) begin
                w_scn_win = (r_wait_cnt == WAIT_LIMIT);
            end else begin
                // Alternate: whoever did not win last time wins now.
                w_scn_win = (r_last_gnt == GNT_CPU);
            end
            w_cpu_win = !w_scn_win;
        end else begin
            w_cpu_win = cpu_req;
            w_scn_win = scn_req;
        end
        if (!rst_n) begin
            w_cpu_win = 1'b0;
            w_scn_win = 1'b0;
        end
    end

    // Memory-side muxing. The scanner is read-only, so mem_we only follows a
    // CPU grant. With no grant the CPU address is presented (harmless read).
    always_comb begin
        mem_addr  = w_scn_win ? scn_addr : cpu_addr;
        mem_we    = w_cpu_win && cpu_we;
        mem_wdata = cpu_wdata;
        scn_gnt   = w_scn_win;
        cpu_stall = w_scn_win && cpu_req;
        if (!rst_n) begin
            mem_addr = '0;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign scn_rdata  = r_scn_rdata;
    assign scn_rvalid = r_scn_rvalid;
    assign stall_cnt  = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt   <= '0;
            r_last_gnt   <= GNT_CPU;
            r_scn_rdata  <= '0;
            r_scn_rvalid <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            // Scanner waiting counter, saturating at the force-grant limit.
            if (scn_req && !w_scn_win) begin
                if (r_wait_cnt != WAIT_LIMIT) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_cpu_win) begin
                r_last_gnt <= GNT_CPU;
            end else if (w_scn_win) begin
                r_last_gnt <= GNT_SCN;
            end

            // One-cycle read latency: capture the word read during the grant.
            r_scn_rvalid <= w_scn_win;
            if (w_scn_win) begin
                r_scn_rdata <= mem_rdata;
            end

            if (cpu_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int DW = 26;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          scn_req;
    logic [AW-1:0] scn_addr;
    logic          scn_gnt;
    logic [DW-1:0] scn_rdata;
    logic          scn_rvalid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stall_cnt;

    // Second instance (round-robin policy) with its own request lines.
    logic          p1_cpu_req;
    logic          p1_scn_req;
    logic [DW-1:0] p1_cpu_rdata;
    logic          p1_cpu_stall;
    logic          p1_scn_gnt;
    logic [DW-1:0] p1_scn_rdata;
    logic          p1_scn_rvalid;
    logic [AW-1:0] p1_mem_addr;
    logic          p1_mem_we;
    logic [DW-1:0] p1_mem_wdata;
    logic [DW-1:0] p1_mem_rdata;
    logic [15:0]   p1_stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];

    assign mem_rdata    = mem[mem_addr];
    assign p1_mem_rdata = 26'h1234567;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(4), .POLICY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .scn_req(scn_req), .scn_addr(scn_addr), .scn_gnt(scn_gnt),
        .scn_rdata(scn_rdata), .scn_rvalid(scn_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(4), .POLICY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(p1_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(p1_cpu_rdata), .cpu_stall(p1_cpu_stall),
        .scn_req(p1_scn_req), .scn_addr(scn_addr), .scn_gnt(p1_scn_gnt),
        .scn_rdata(p1_scn_rdata), .scn_rvalid(p1_scn_rvalid),
        .mem_addr(p1_mem_addr), .mem_we(p1_mem_we), .mem_wdata(p1_mem_wdata),
        .mem_rdata(p1_mem_rdata), .stall_cnt(p1_stall_cnt)
    );

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05;
        cpu_wdata = 26'h3FFFFFF; scn_req = 1'b0; scn_addr = 8'h00;
        p1_cpu_req = 1'b0; p1_scn_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++;
            if ({mem_we, scn_gnt, cpu_stall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_comb: we/gnt/stall=%b expected 000", {mem_we, scn_gnt, cpu_stall});
            end
            checks++;
            if (mem_addr !== 8'h00) begin
                errors++;
                $display("FAIL reset_addr: mem_addr=%h expected 00", mem_addr);
            end
            next_cycle();
        end
        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        checks++;
        if ({scn_rvalid, stall_cnt, scn_rdata} !== {1'b0, 16'h0000, 26'h0}) begin
            errors++;
            $display("FAIL reset_state: rvalid=%b stall_cnt=%h rdata=%h expected 0/0000/0",
                     scn_rvalid, stall_cnt, scn_rdata);
        end
        $display("test_reset done");
    endtask

    task automatic test_cpu_store_load();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 26'h0ABCDEF;
        #1;
        checks++;
        if ({mem_we, cpu_stall, scn_gnt, mem_addr} !== {1'b1, 1'b0, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL cpu_store: we=%b stall=%b gnt=%b addr=%h expected 1/0/0/05",
                     mem_we, cpu_stall, scn_gnt, mem_addr);
        end
        next_cycle();
        cpu_we = 1'b0;
        #1;
        checks++;
        if ({cpu_rdata, mem_we, cpu_stall} !== {26'h0ABCDEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cpu_load: rdata=%h we=%b stall=%b expected 0abcdef/0/0",
                     cpu_rdata, mem_we, cpu_stall);
        end
        next_cycle();
        cpu_req = 1'b0;
        $display("test_cpu_store_load done");
    endtask

    task automatic test_scanner_read();
        cpu_we = 1'b1; scn_req = 1'b1; scn_addr = 8'h05;
        #1;
        checks++;
        if ({scn_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL scn_grant: gnt=%b we=%b addr=%h expected 1/0/05", scn_gnt, mem_we, mem_addr);
        end
        next_cycle();
        scn_req = 1'b0; cpu_we = 1'b0;
        #1;
        checks++;
        if ({scn_rvalid, scn_rdata} !== {1'b1, 26'h0ABCDEF}) begin
            errors++;
            $display("FAIL scn_rdata: rvalid=%b rdata=%h expected 1/0abcdef", scn_rvalid, scn_rdata);
        end
        next_cycle();
        checks++;
        if ({scn_rvalid, scn_rdata, mem_we} !== {1'b0, 26'h0ABCDEF, 1'b0}) begin
            errors++;
            $display("FAIL scn_pulse: rvalid=%b rdata=%h we=%b expected 0/0abcdef/0",
                     scn_rvalid, scn_rdata, mem_we);
        end
        $display("test_scanner_read done");
    endtask

    task automatic test_starvation();
        logic exp_s;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05; scn_req = 1'b1; scn_addr = 8'h05;
        for (int c = 0; c < 6; c++) begin
            exp_s = (c == 4);
            #1;
            checks++;
            if ({scn_gnt, cpu_stall} !== {exp_s, exp_s}) begin
                errors++;
                $display("FAIL starve_c%0d: gnt=%b stall=%b expected %b/%b",
                         c, scn_gnt, cpu_stall, exp_s, exp_s);
            end
            next_cycle();
        end
        cpu_req = 1'b0; scn_req = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL starve_cnt: stall_cnt=%0d expected 1", stall_cnt);
        end
        next_cycle();
        $display("test_starvation done");
    endtask

    task automatic test_round_robin();
        logic exp_s;
        p1_cpu_req = 1'b1; p1_scn_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_s = (c % 2 == 0);
            #1;
            checks++;
            if ({p1_scn_gnt, p1_cpu_stall, p1_mem_we} !== {exp_s, exp_s, 1'b0}) begin
                errors++;
                $display("FAIL rr_c%0d: gnt=%b stall=%b we=%b expected %b/%b/0",
                         c, p1_scn_gnt, p1_cpu_stall, p1_mem_we, exp_s, exp_s);
            end
            next_cycle();
        end
        p1_cpu_req = 1'b0; p1_scn_req = 1'b0;
        #1;
        checks++;
        if (p1_stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL rr_cnt: stall_cnt=%0d expected 3", p1_stall_cnt);
        end
        next_cycle();
        $display("test_round_robin done");
    endtask

    task automatic test_saturation_mid_reset();
        force dut0.r_stall_cnt = 16'hFFFE;
        next_cycle();
        release dut0.r_stall_cnt;
        checks++;
        if (stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: stall_cnt=%h expected fffe", stall_cnt);
        end
        // With MAX_WAIT=4, both held: stalls on cycles 4, 9 and 14.
        cpu_req = 1'b1; cpu_we = 1'b0; scn_req = 1'b1;
        for (int c = 0; c < 15; c++) begin
            next_cycle();
            if (c == 4) begin
                checks++;
                if (stall_cnt !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL sat_first: stall_cnt=%h expected ffff", stall_cnt);
                end
            end
        end
        cpu_req = 1'b0; scn_req = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: stall_cnt=%h expected ffff", stall_cnt);
        end
        next_cycle();
        // Scanner grant, then reset lands within the same cycle.
        scn_req = 1'b1; scn_addr = 8'h05;
        #1;
        checks++;
        if (scn_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt: gnt=%b expected 1", scn_gnt);
        end
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 26'h1111111;
        #1;
        checks++;
        if ({scn_gnt, mem_we, cpu_stall, mem_addr} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL mid_comb: gnt=%b we=%b stall=%b addr=%h expected 0/0/0/00",
                     scn_gnt, mem_we, cpu_stall, mem_addr);
        end
        next_cycle();
        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; scn_req = 1'b0;
        #1;
        checks++;
        if ({scn_rvalid, scn_rdata, stall_cnt, p1_stall_cnt} !== {1'b0, 26'h0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL mid_state: rvalid=%b rdata=%h cnt=%h p1cnt=%h expected 0/0/0/0",
                     scn_rvalid, scn_rdata, stall_cnt, p1_stall_cnt);
        end
        checks++;
        if (mem[8'h05] !== 26'h0ABCDEF) begin
            errors++;
            $display("FAIL mid_nowrite: mem[05]=%h expected 0abcdef", mem[8'h05]);
        end
        // wait_cnt cleared: CPU must win the next contended cycle.
        cpu_req = 1'b1; scn_req = 1'b1;
        #1;
        checks++;
        if ({scn_gnt, cpu_stall} !== 2'b00) begin
            errors++;
            $display("FAIL mid_wait: gnt=%b stall=%b expected 0/0", scn_gnt, cpu_stall);
        end
        next_cycle();
        cpu_req = 1'b0; scn_req = 1'b0;
        next_cycle();
        $display("test_saturation_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_cpu_store_load();
        test_scanner_read();
        test_starvation();
        test_round_robin();
        test_saturation_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU datapath (load/store) and a display scanner that reads puzzle-cell words for the 7-segment io.
- Sits between the decoder/ALU/regfile and the memory block, and runs on the divided clock.
- Resolves contention every cycle and stalls the CPU when it loses the port.
- Guarantees the scanner forward progress and provides a saturating stall counter for debug.

Parameters:
- DW, 26, data word width. Matches the ALU and regfile width.
- AW, 8, memory address width. The CPU address is the low AW bits of the register operand.
- MAX_WAIT, 4, number of consecutive denied scanner cycles after which the scanner is force-granted. Legal range 1..15.
- POLICY, 0, contention policy. 0 = CPU priority with starvation guard; 1 = strict alternation (round-robin).

Ports:
- clk  in  1  divided system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU wants the memory this cycle (load or store decoded).
- cpu_we  in  1  CPU access is a store.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU store data (ALU output).
- cpu_rdata  out  DW  load data to the write-back selector. Equals mem_rdata, combinational.
- cpu_stall  out  1  CPU lost arbitration this cycle. The decoder gates pc_we, reg_we and mem_we with it.
- scn_req  in  1  scanner read request.
- scn_addr  in  AW  scanner address.
- scn_gnt  out  1  scanner owns the port this cycle.
- scn_rdata  out  DW  registered scanner read data.
- scn_rvalid  out  1  scn_rdata valid. One-cycle pulse.
- mem_addr  out  AW  to memory.
- mem_we  out  1  to memory.
- mem_wdata  out  DW  to memory.
- mem_rdata  in  DW  from memory. Combinational read of mem_addr.
- stall_cnt  out  16  saturating count of cpu_stall cycles.

Behaviour:
- Reset: sampled at the clk edge when rst_n=0.
  - Clears wait_cnt=0, last_gnt=CPU, scn_rdata=0, scn_rvalid=0, stall_cnt=0.
  - While rst_n=0, the combinational outputs are forced to scn_gnt=0, cpu_stall=0, mem_we=0, mem_addr=0.
- Grant decision is combinational within the cycle:
  - Neither requester: no grant, mem_we=0, mem_addr=cpu_addr.
  - cpu_req only: CPU granted.
  - scn_req only: scanner granted.
  - Both, POLICY=0: CPU granted unless wait_cnt==MAX_WAIT, in which case the scanner is granted.
  - Both, POLICY=1: the requester that was not last_gnt is granted.
- CPU granted: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, cpu_stall=0.
- Scanner granted: mem_addr=scn_addr, mem_we=0, mem_wdata=cpu_wdata (don't-care, since we=0), scn_gnt=1. cpu_stall=cpu_req.
- The scanner can never write. mem_we is asserted only on a CPU grant with cpu_we=1.
- Scanner read latency is 1 cycle. On the edge ending a scan-grant cycle, scn_rdata<=mem_rdata and scn_rvalid<=1; otherwise scn_rvalid<=0 and scn_rdata holds.
- A scanner request that is granted is retired in that cycle. The scanner must keep scn_req/scn_addr stable until it sees scn_gnt. It may issue back-to-back requests; rvalid then follows each grant by one cycle.
- wait_cnt (4 bits):
  - Increments on each edge where scn_req=1 and scn_gnt=0.
  - Clears to 0 on a scanner grant or when scn_req=0.
  - Saturates at MAX_WAIT. It is only used when POLICY=0 but is maintained in both modes.
- last_gnt updates on every granted cycle to the winner, and holds on idle cycles.
- A stalled CPU holds its request. The next cycle re-arbitrates, and under POLICY=0 the CPU then wins because wait_cnt has cleared. This bounds CPU stalls to 1 consecutive cycle under POLICY=0 and under POLICY=1.
- stall_cnt increments on each edge with cpu_stall=1. It saturates at 16'hFFFF and never wraps.
- Reset asserted mid-access: the in-flight scanner read is dropped (scn_rvalid=0 next cycle), and no write occurs in the reset cycle.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with cpu_req=1, cpu_we=1. Required: mem_we=0, scn_gnt=0, cpu_stall=0, scn_rvalid=0 and stall_cnt=0 after release.
- CPU-only store then load: store addr 8'h05, data 26'h0ABCDEF. Required: mem_we=1 that cycle. A load of 8'h05 next cycle returns cpu_rdata=26'h0ABCDEF, cpu_stall=0.
- Scanner-only read: scn_req=1, scn_addr=8'h05. Required: scn_gnt=1 same cycle, scn_rvalid=1 with scn_rdata=26'h0ABCDEF the next cycle, and mem_we=0 throughout.
- POLICY=0 starvation guard: cpu_req and scn_req both held high with MAX_WAIT=4. Required: CPU granted for cycles 0–3; scanner granted at cycle 4 with cpu_stall=1; CPU granted at cycle 5. stall_cnt=1.
- POLICY=1 contention: both requesters held high for 6 cycles starting from last_gnt=CPU. Required: grants alternate S,C,S,C,S,C; cpu_stall=1 on cycles 0,2,4; stall_cnt=3.
- Saturation and mid-reset: preload stall_cnt to 16'hFFFE (force), then cause 3 stalls. Required: stall_cnt=16'hFFFF. Then assert rst_n=0 during a scanner grant. Required: no scn_rvalid pulse follows, and all state is cleared.
